fifo_flex: RTL and testbench

- Parametrised synchronous valid/ready FIFO; next generation of the team's basic stream FIFO.
- Adds the following over the basic FIFO:
  - arbitrary (non-power-of-two) depth with correct pointer wrap;
  - programmable almost-full and almost-empty thresholds;
  - a live occupancy count;
  - a synchronous flush.
- Sits between stream producers and consumers in the datapath.
- All status and output signals are registered.

---
 rtl/fifo_flex_pkg.sv | 32 +++
 rtl/fifo_wrap_ptr.sv | 26 ++
 rtl/fifo_flex.sv | 113 +++++++++++
 tb/tb_fifo_flex.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// Shared definitions for the fifo_flex stream FIFO: width helpers, parameter
// legality check and the transfer encoding used by the level update.
package fifo_flex_pkg;

  // Never returns 0, so a 1-entry range still gets a 1-bit register.
  function automatic int width_of(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int ptr_width(input int depth);
    return width_of(depth);
  endfunction

  function automatic int lvl_width(input int depth);
    return width_of(depth + 1);
  endfunction

  function automatic bit params_legal(input int depth, input int afull, input int aempty);
    return (depth >= 2) && (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_WR   = 2'b01,
    XFER_RD   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-N pointer with increment enable and synchronous clear; wraps from
// N-1 back to 0 by explicit compare, so N need not be a power of two.
module fifo_wrap_ptr
  import fifo_flex_pkg::*;
#(
  parameter int N = 8,
  localparam int W = ptr_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_flex.sv
// Synchronous valid/ready FIFO with arbitrary depth, programmable almost
// thresholds, live level and flush; the head word lives in a registered odata.
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  localparam int LVL_WIDTH    = lvl_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LVL_WIDTH-1:0]  level
);

  localparam int PTR_WIDTH = ptr_width(FIFO_DEPTH);
  localparam logic [LVL_WIDTH-1:0] DEPTH_L = LVL_WIDTH'(FIFO_DEPTH);
  localparam logic [LVL_WIDTH-1:0] AF_L    = LVL_WIDTH'(AFULL_THRESH);
  localparam logic [LVL_WIDTH-1:0] AE_L    = LVL_WIDTH'(AEMPTY_THRESH);

  if (!params_legal(FIFO_DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("fifo_flex: illegal FIFO_DEPTH or threshold parameter");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [LVL_WIDTH-1:0]  mem_cnt, mem_cnt_next, level_next;
  logic                  wr, rd, load;
  xfer_e                 xfer;

  // mem_cnt counts words still in the array, i.e. level minus the output word.
  always_comb begin
    wr           = ivalid & iready & ~flush & ~rst;
    rd           = ovalid & oready & ~flush & ~rst;
    load         = (~ovalid | rd) & (mem_cnt != '0);
    xfer         = xfer_e'({rd, wr});
    level_next   = level;
    case (xfer)
      XFER_WR: level_next = level + 1'b1;
      XFER_RD: level_next = level - 1'b1;
      default: level_next = level;
    endcase
    mem_cnt_next = mem_cnt + LVL_WIDTH'(wr) - LVL_WIDTH'(load);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level        <= '0;
      mem_cnt      <= '0;
      iready       <= 1'b1;
      ovalid       <= 1'b0;
      odata        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      level        <= '0;
      mem_cnt      <= '0;
      iready       <= 1'b1;
      ovalid       <= 1'b0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      level        <= level_next;
      mem_cnt      <= mem_cnt_next;
      iready       <= (level_next < DEPTH_L);
      full         <= (level_next == DEPTH_L);
      almost_full  <= (level_next >= AF_L);
      almost_empty <= (level_next <= AE_L);
      if (~ovalid | rd) begin
        ovalid <= load;
      end
      if (load) begin
        odata <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= idata;
    end
  end

  fifo_wrap_ptr #(.N(FIFO_DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (wr),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.N(FIFO_DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (load),
    .ptr (rd_ptr)
  );

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex (DEPTH=5, AFULL=4, AEMPTY=1): a vector
// table for fill/drain, a queue scoreboard, and hand-written corner sequences.
module tb_fifo_flex;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush, ivalid, oready;
  logic [DW-1:0] idata;
  logic          iready, ovalid, full, almost_full, almost_empty;
  logic [DW-1:0] odata;
  logic [LW-1:0] level;

  int n_cmp = 0;
  int n_bad = 0;
  int n_reads = 0;
  int n_writes = 0;

  logic [DW-1:0] sb[$];
  logic          m_ovalid = 1'b0;
  logic [DW-1:0] saved;

  typedef struct {
    logic          r, f, iv;
    logic [DW-1:0] d;
    logic          ordy;
    int            lvl;
    logic          ov, ir, fu, af, ae;
    logic [DW-1:0] od;
  } vec_t;

  vec_t vecs[13];

  fifo_flex #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .AFULL_THRESH (AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .idata       (idata),
    .ivalid      (ivalid),
    .iready      (iready),
    .odata       (odata),
    .ovalid      (ovalid),
    .oready      (oready),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [DW-1:0] d, input logic ordy);
    rst    = r;
    flush  = f;
    ivalid = iv;
    idata  = d;
    oready = ordy;
  endtask

  // Model state: sb holds every word inside the FIFO in order, the head being
  // on odata whenever m_ovalid is set.
  task automatic checkOutput();
    check("level", level, sb.size());
    check("iready", iready, sb.size() < DEPTH);
    check("full", full, sb.size() == DEPTH);
    check("almost_full", almost_full, sb.size() >= AF);
    check("almost_empty", almost_empty, sb.size() <= AE);
    check("ovalid", ovalid, m_ovalid);
    if (m_ovalid) check("head_data", odata, sb[0]);
  endtask

  task automatic step();
    bit            m_wr, m_rd;
    int            mem_words;
    logic [DW-1:0] d;
    d         = idata;
    m_wr      = !rst && !flush && ivalid && (sb.size() < DEPTH);
    m_rd      = !rst && !flush && m_ovalid && oready;
    mem_words = sb.size() - (m_ovalid ? 1 : 0);
    if (m_rd) begin
      check("read_data", odata, sb[0]);
      n_reads++;
    end
    @(posedge clk);
    #1;
    if (rst || flush) begin
      sb.delete();
      m_ovalid = 1'b0;
    end else begin
      if (m_rd) void'(sb.pop_front());
      if (!m_ovalid || m_rd) m_ovalid = (mem_words > 0);
      if (m_wr) begin
        sb.push_back(d);
        n_writes++;
      end
    end
    checkOutput();
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h14, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h16, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h13};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h14};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h15};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};

    // Reset for three cycles, then ten idle cycles with nothing moving.
    for (int i = 0; i < 3; i++) step();
    check("rst_odata", odata, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_iready", iready, 1'b1);
      check("idle_ovalid", ovalid, 1'b0);
      check("idle_level", level, 0);
      check("idle_aempty", almost_empty, 1'b1);
      check("idle_full", full, 1'b0);
    end

    // Fill to full with backpressure, reject a sixth word, then drain.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      step();
      check("vec_level", level, vecs[i].lvl);
      check("vec_ovalid", ovalid, vecs[i].ov);
      check("vec_iready", iready, vecs[i].ir);
      check("vec_full", full, vecs[i].fu);
      check("vec_afull", almost_full, vecs[i].af);
      check("vec_aempty", almost_empty, vecs[i].ae);
      if (vecs[i].ov) check("vec_odata", odata, vecs[i].od);
    end

    // 23 words streamed through, reads trailing writes; pointers wrap repeatedly.
    n_reads  = 0;
    n_writes = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, n_writes < 23, 8'h40 + 8'(n_writes), 1'b1);
      step();
    end
    check("wrap_writes", n_writes, 23);
    check("wrap_reads", n_reads, 23);

    // Read and write offered together while full: only the read happens.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h50 + 8'(i), 1'b0);
      step();
    end
    check("sim_full_before", full, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
    step();
    check("sim_level_after_read", level, 4);
    check("sim_iready_back", iready, 1'b1);
    check("sim_head_next", odata, 8'h51);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    step();
    check("sim_pending_write", level, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) step();
    check("sim_drained", level, 0);

    // Head word held stable while the consumer stalls.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("bp_odata", odata, 8'hA5);
      check("bp_ovalid", ovalid, 1'b1);
      check("bp_level", level, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step();

    // Flush with both handshakes offered at level 3.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h31 + 8'(i), 1'b0);
      step();
    end
    check("fl_level_before", level, 3);
    saved = odata;
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
    step();
    check("fl_level", level, 0);
    check("fl_ovalid", ovalid, 1'b0);
    check("fl_iready", iready, 1'b1);
    check("fl_odata_kept", odata, saved);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
    step();
    check("fl_w1_ovalid", ovalid, 1'b0);
    check("fl_w1_level", level, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check("fl_w2_ovalid", ovalid, 1'b1);
    check("fl_w2_odata", odata, 8'h3C);

    // Reset in mid-stream with traffic offered discards everything.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h78, 1'b1);
    step();
    check("mrst_level", level, 0);
    check("mrst_odata", odata, 8'h00);
    check("mrst_ovalid", ovalid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
